// File: rtl/rr_mux_scheduler.sv
// Round-robin scheduler for a shared 4:1 mux channel: grants one of four
// requesters at a time for bursts of up to MAX_BURST beats onto y.
module rr_mux_scheduler #(
    parameter int DW        = 2,
    parameter int MAX_BURST = 4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          en,
    input  logic [3:0]    req,
    input  logic [DW-1:0] a,
    input  logic [DW-1:0] b,
    input  logic [DW-1:0] c,
    input  logic [DW-1:0] d,
    output logic [DW-1:0] y,
    output logic          y_valid,
    output logic [1:0]    sel,
    output logic [3:0]    gnt,
    output logic          busy
);

    localparam int CW = $clog2(MAX_BURST) + 1;

    typedef enum logic {
        IDLE,
        GRANT
    } state_t;

    state_t          state;
    logic [CW-1:0]   cnt;
    logic [1:0]      ptr;

    logic [1:0]      arb_base;
    logic [1:0]      scan_idx;
    logic [1:0]      win;
    logic            win_found;
    logic [DW-1:0]   src_data;
    logic            last_beat;
    logic            exit_burst;

    // Scan starts at ptr when idle, and right after the current owner when
    // leaving a burst, so the outgoing source is considered last.
    // NOTE: every signal written in always_comb gets a default first so no latch is inferred.
    always_comb begin
        arb_base  = (state == GRANT) ? sel + 2'd1 : ptr;
        win       = 2'd0;
        win_found = 1'b0;
        scan_idx  = arb_base;
        for (int i = 0; i < 4; i++) begin
            scan_idx = arb_base + 2'(i);
            if (!win_found && req[scan_idx]) begin
                win       = scan_idx;
                win_found = 1'b1;
            end
        end
    end

    always_comb begin
        case (sel)
            2'd0:    src_data = a;
            2'd1:    src_data = b;
            2'd2:    src_data = c;
            default: src_data = d;
        endcase
    end

    assign busy       = (state == GRANT);
    assign y_valid    = busy && en && req[sel];
    assign y          = y_valid ? src_data : '0;
    assign last_beat  = y_valid && (cnt == CW'(MAX_BURST - 1));
    assign exit_burst = busy && ((en && !req[sel]) || last_beat);

    // NOTE: sequential state uses non-blocking assignments only, so every
    // register samples the pre-edge values of its neighbours.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            sel   <= 2'd0;
            gnt   <= 4'b0000;
            cnt   <= '0;
            ptr   <= 2'd0;
        end else begin
            case (state)
                IDLE: begin
                    if (en && win_found) begin
                        state <= GRANT;
                        sel   <= win;
                        gnt   <= 4'b0001 << win;
                        cnt   <= '0;
                    end
                end
                GRANT: begin
                    if (exit_burst) begin
                        ptr <= sel + 2'd1;
                        cnt <= '0;
                        // Hand over directly when someone is waiting; no idle bubble.
                        if (win_found) begin
                            sel <= win;
                            gnt <= 4'b0001 << win;
                        end else begin
                            state <= IDLE;
                            gnt   <= 4'b0000;
                        end
                    end else if (y_valid) begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: begin
                    state <= IDLE;
                    gnt   <= 4'b0000;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_rr_mux_scheduler.sv
// Directed bench for rr_mux_scheduler: inputs change 1 ns after each rising
// edge, outputs are compared 1 ns later, well away from the next edge.
module tb_rr_mux_scheduler;

    localparam int DW = 2;

    logic          clk = 1'b0;
    logic          rst;
    logic          en;
    logic [3:0]    req;
    logic [DW-1:0] a, b, c, d;
    logic [DW-1:0] y;
    logic          y_valid;
    logic [1:0]    sel;
    logic [3:0]    gnt;
    logic          busy;

    int total = 0;
    int bad   = 0;

    rr_mux_scheduler #(.DW(DW), .MAX_BURST(4)) dut (
        .clk(clk), .rst(rst), .en(en), .req(req),
        .a(a), .b(b), .c(c), .d(d),
        .y(y), .y_valid(y_valid), .sel(sel), .gnt(gnt), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reset pulse placed between edges; leaves ptr=0 and the block idle.
    task automatic do_reset();
        @(posedge clk);
        #1 rst = 1'b1;
        #2 rst = 1'b0;
    endtask

    task automatic expect_grant(input string tag, input logic [3:0] g, input logic [1:0] s,
                                input logic v, input logic [DW-1:0] data);
        check({tag, ".gnt"}, gnt, g);
        check({tag, ".sel"}, sel, s);
        check({tag, ".busy"}, busy, g != 4'b0000);
        check({tag, ".y_valid"}, y_valid, v);
        check({tag, ".y"}, y, data);
    endtask

    initial begin
        logic [DW-1:0] src [4];
        rst = 1'b1; en = 1'b0; req = 4'b0000;
        a = 2'b11; b = 2'b01; c = 2'b10; d = 2'b11;
        #2;
        expect_grant("reset", 4'b0000, 2'd0, 1'b0, 2'b00);
        #2 rst = 1'b0;

        // 1. reset mid-burst: b granted, two beats counted, then rst between edges
        en = 1'b1; req = 4'b0010;
        tick(); expect_grant("t1.grant", 4'b0010, 2'd1, 1'b1, 2'b01);
        tick(); tick();
        rst = 1'b1; #1;
        expect_grant("t1.rst", 4'b0000, 2'd0, 1'b0, 2'b00);
        #1 rst = 1'b0;
        tick(); expect_grant("t1.regrant", 4'b0010, 2'd1, 1'b1, 2'b01);

        // 2. single requester held: back-to-back bursts with no gap
        req = 4'b0000;
        do_reset();
        a = 2'b10; req = 4'b0001;
        for (int k = 1; k <= 10; k++) begin
            tick();
            expect_grant($sformatf("t2.c%0d", k), 4'b0001, 2'd0, 1'b1, 2'b10);
        end

        // 3. all requesting: a,b,c,d,a with 4 beats each
        req = 4'b0000;
        do_reset();
        a = 2'b11; b = 2'b01; c = 2'b10; d = 2'b00;
        src[0] = 2'b11; src[1] = 2'b01; src[2] = 2'b10; src[3] = 2'b00;
        req = 4'b1111;
        for (int k = 1; k <= 17; k++) begin
            int s;
            s = ((k - 1) / 4) % 4;
            tick();
            expect_grant($sformatf("t3.c%0d", k), 4'b0001 << s, 2'(s), 1'b1, src[s]);
        end

        // 4. early drop: c drops after 2 beats, d takes over on the next edge
        req = 4'b0000;
        do_reset();
        c = 2'b10; d = 2'b01; req = 4'b0100;
        tick(); expect_grant("t4.c_beat1", 4'b0100, 2'd2, 1'b1, 2'b10);
        req = 4'b1100;
        tick(); expect_grant("t4.c_beat2", 4'b0100, 2'd2, 1'b1, 2'b10);
        req = 4'b1000; #1;
        expect_grant("t4.dropped", 4'b0100, 2'd2, 1'b0, 2'b00);
        tick(); expect_grant("t4.d", 4'b1000, 2'd3, 1'b1, 2'b01);
        // ptr now sits past c; after d's burst nobody but a requests
        req = 4'b1001;
        for (int k = 0; k < 3; k++) tick();
        tick(); expect_grant("t4.a_after_d", 4'b0001, 2'd0, 1'b1, 2'b11);

        // 5. en pause: d held with one beat done, then 3 more beats
        req = 4'b0000;
        do_reset();
        d = 2'b01; req = 4'b1000;
        tick(); expect_grant("t5.beat0", 4'b1000, 2'd3, 1'b1, 2'b01);
        req = 4'b1001;
        tick(); en = 1'b0;
        for (int k = 0; k < 3; k++) begin
            #1 expect_grant($sformatf("t5.pause%0d", k), 4'b1000, 2'd3, 1'b0, 2'b00);
            tick();
        end
        en = 1'b1; #1;
        expect_grant("t5.resume1", 4'b1000, 2'd3, 1'b1, 2'b01);
        tick(); expect_grant("t5.resume2", 4'b1000, 2'd3, 1'b1, 2'b01);
        tick(); expect_grant("t5.resume3", 4'b1000, 2'd3, 1'b1, 2'b01);
        tick(); expect_grant("t5.exit_to_a", 4'b0001, 2'd0, 1'b1, 2'b11);

        // 6. no requests: stays idle, then c granted one edge after req rises
        req = 4'b0000;
        do_reset();
        for (int k = 0; k < 5; k++) begin
            tick();
            expect_grant($sformatf("t6.idle%0d", k), 4'b0000, 2'd0, 1'b0, 2'b00);
        end
        c = 2'b11; req = 4'b0100; #1;
        check("t6.pre_gnt", gnt, 4'b0000);
        tick(); expect_grant("t6.c", 4'b0100, 2'd2, 1'b1, 2'b11);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
